// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: data word, address, FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    localparam int WORD_WIDTH     = 8;
    localparam int ADDR_WIDTH_DEF = 8;

    typedef logic [WORD_WIDTH-1:0]     word;
    typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT
    } arb_state_e;

    // Read-latency counter width; never narrower than one bit.
    function automatic int cnt_width(input int lat);
        int w;
        w = $clog2(lat + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin selector: picks the requester not granted last on contention.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       any,
    output logic       sel
);

    always_comb begin
        any = |req;
        sel = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between two requesters, one access in flight at a time.
// Latency: gnt one cycle after sampling; rvalid RD_LAT+1 cycles after gnt.
// Backpressure: requests are only sampled in IDLE; requesters hold until gnt.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH      = WORD_WIDTH,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  wr0,
    input  logic                  wr1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0]      wdata0,
    input  logic [WIDTH-1:0]      wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [WIDTH-1:0]      rdata0,
    output logic [WIDTH-1:0]      rdata1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_data,
    output logic                  mem_wr,
    input  logic [WIDTH-1:0]      mem_rd_data
);

    localparam int              CNT_W    = cnt_width(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    arb_state_e            state_q, state_d;
    logic                  sel_q, sel_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic                  last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]      rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic                  pick_any, pick_sel;
    logic                  capture;

    rr_pick u_rr_pick (
        .req  ({req1, req0}),
        .last (last_gnt_q),
        .any  (pick_any),
        .sel  (pick_sel)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        capture    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_sel;
                    wr_d    = pick_sel ? wr1 : wr0;
                    addr_d  = pick_sel ? addr1 : addr0;
                    wdata_d = pick_sel ? wdata1 : wdata0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                last_gnt_d = sel_q;
                if (wr_q) begin
                    state_d = ST_IDLE;
                end else if (RD_LAT == 0) begin
                    capture = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Read data lands in the owning port's register; rvalid follows one cycle later.
        if (capture) begin
            if (sel_q) begin
                rdata1_d  = mem_rd_data;
                rvalid1_d = 1'b1;
            end else begin
                rdata0_d  = mem_rd_data;
                rvalid0_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            last_gnt_q <= 1'b1;
            cnt_q      <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
        end
    end

    always_comb begin
        gnt0     = (state_q == ST_ACCESS) && !sel_q;
        gnt1     = (state_q == ST_ACCESS) &&  sel_q;
        mem_wr   = (state_q == ST_ACCESS) &&  wr_q;
        mem_addr = addr_q;
        mem_data = wdata_q;
        rvalid0  = rvalid0_q;
        rvalid1  = rvalid1_q;
        rdata0   = rdata0_q;
        rdata1   = rdata1_q;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-port data `memory` between the `cpu` data port (requester 0) and a second bus master (requester 1: debug/loader or I/O engine). It captures one request at a time, drives the RAM's address, write-data and write-enable lines from registers, and returns read data with a valid pulse. Requesters that raise `req` together are served in round-robin order. It sits in `io_unit` between `CPU`/second master and `RAM`.

## Interface
Parameters:
- `WIDTH`, 8: data width. Equals the width of `word`.
- `ADDR_WIDTH`, 8: address width.
- `RD_LAT`, 1: RAM read latency in cycles, from address driven to `mem_rd_data` valid. Legal range 0..3.

Ports:
- `clk`  in  1: the single clock. All state is on its rising edge.
- `rst`  in  1: reset. Asynchronous, active-high.
- `req0`, `req1`  in  1: access request.
- `wr0`, `wr1`  in  1: 1 = write, 0 = read.
- `addr0`, `addr1`  in  ADDR_WIDTH: access address.
- `wdata0`, `wdata1`  in  WIDTH: write data.
- `gnt0`, `gnt1`  out  1: one-cycle pulse. The request has been accepted and is being issued.
- `rvalid0`, `rvalid1`  out  1: one-cycle pulse. `rdataN` holds the read result.
- `rdata0`, `rdata1`  out  WIDTH: read data. Registered; holds its value until the next read completes for that port.
- `mem_addr`  out  ADDR_WIDTH: RAM address.
- `mem_data`  out  WIDTH: RAM write data.
- `mem_wr`  out  1: RAM write enable.
- `mem_rd_data`  in  WIDTH: RAM read data.

## Operation
- FSM states:
  - IDLE: sample requests.
  - ACCESS: drive the RAM for one cycle; `gntN` is high.
  - WAIT: count `RD_LAT` cycles. Used for reads only.
- IDLE, no request: stay in IDLE.
- IDLE, at least one `reqN` high at the clock edge:
  - Select the winner.
  - Capture `sel`, `wrN`, `addrN` and `wdataN` into registers.
  - Go to ACCESS.
- Round-robin rule:
  - If only one request is high, that requester wins.
  - If both are high, the requester not granted last wins.
  - `last_gnt` resets to 1, so requester 0 wins the first contested cycle.
- ACCESS:
  - `gnt[sel]` = 1.
  - `mem_addr` and `mem_data` come from the captured registers.
  - `mem_wr` = captured `wr`.
  - `last_gnt` <= `sel`.
  - Write: go to IDLE.
  - Read with `RD_LAT` = 0: capture `mem_rd_data` into `rdata[sel]`, then go to IDLE.
  - Read with `RD_LAT` > 0: go to WAIT with the counter at `RD_LAT`-1.
- WAIT:
  - `mem_addr` is held and `mem_wr` = 0.
  - The counter decrements each cycle.
  - When the counter is 0: capture `mem_rd_data` into `rdata[sel]`, then go to IDLE.
- `rvalid[sel]` pulses in the cycle after the capture. That cycle is IDLE, so the next request is sampled at its end.
- Requester rules:
  - Hold `req`, `wr`, `addr` and `wdata` stable until `gnt` is seen.
  - The arbiter does not sample `req` in ACCESS or WAIT.
  - A `req` still high after the `gnt` cycle is a new transaction.
  - Dropping `req` before it is sampled withdraws the request without side effects.
- Reset, asynchronous, effective at any state:
  - State = IDLE.
  - All outputs = 0.
  - Captured registers = 0.
  - `last_gnt` = 1.
  - A read in flight is dropped and no `rvalid` is produced.

## Timing
- Reset value of every output is 0: `gntN`, `rvalidN`, `rdataN`, `mem_addr`, `mem_data`, `mem_wr`.
- The request is sampled at edge k. `gnt` and `mem_wr` (for a write) are high in cycle k+1 only.
- Write throughput: one access per 2 cycles.
- Read: `rvalid` is high `RD_LAT`+1 cycles after the `gnt` cycle.
  - `RD_LAT` = 1: `gnt` in cycle k+1, `rvalid` in cycle k+3.
- Read throughput: one access per `RD_LAT`+2 cycles.
- `mem_wr` is never high outside ACCESS.
- `gnt0` and `gnt1` are never high in the same cycle, and neither are `rvalid0` and `rvalid1`.
- The counter is `$clog2(RD_LAT+1)` bits wide, with a minimum of 1 bit.

## Structure
- The state enum (IDLE/ACCESS/WAIT) goes in the shared package alongside `word`.
- The arbiter's address type (`ADDR_WIDTH` bits) is declared as a typedef in the same package.
- Sub-module `rr_pick`: combinational 2-way round-robin selector.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `any`, `sel`.
- Everything else sits in `mem_arbiter`.
- `io_unit` instantiates `mem_arbiter` between `CPU` and `RAM`.

## Test plan
- Reset: assert `rst` mid-cycle. All outputs go to 0 immediately, and FSM = IDLE.
- Write, port 0: `req0`=1, `wr0`=1, `addr0`=0x10, `wdata0`=0xA5.
  - Next cycle: `gnt0`=1, `mem_wr`=1, `mem_addr`=0x10, `mem_data`=0xA5.
  - `mem_wr` is high for exactly 1 cycle.
- Read, port 1, `RD_LAT`=1: `addr1`=0x10, issued after the write above.
  - `gnt1` pulses, then 2 cycles later `rvalid1`=1 with `rdata1`=0xA5.
  - `rdata0` is unchanged.
- Contention: `req0` and `req1` held high with writes.
  - Grants alternate 0,1,0,1, starting with port 0 after reset.
  - `gnt` is never high for both ports at once.
- Reset during WAIT of a read: no `rvalid` is produced. After release, a new port-1 read to 0x10 returns 0xA5.
- Repeat the read scenario with `RD_LAT`=0 and `RD_LAT`=2: `rvalid` arrives 1 and 3 cycles after `gnt` respectively.
